// File: rtl/pbit_pkg.sv
// Shared p-bit network definitions: fixed-point sizes, histogram reader states
// and the spin tap used at the p-bit array outputs.
package pbit_pkg;

    localparam int FLOAT_SIZE = 24;
    localparam int INT_SIZE   = 8;
    localparam int PVAL_W     = INT_SIZE + FLOAT_SIZE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        BURN    = 3'd2,
        COLLECT = 3'd3,
        DUMP    = 3'd4,
        DONE    = 3'd5
    } hist_state_e;

    // A non-negative p-bit value reads as spin +1 (1), a negative one as -1 (0).
    function automatic logic spin_from_pval(input logic [PVAL_W-1:0] pval);
        return ~pval[PVAL_W-1];
    endfunction

endpackage

// File: rtl/pbit_hist_bank.sv
// Bank of 2^NBITS saturating CW-bit histogram counters with one clear port,
// one increment port and a combinational read port. Storage is not reset.
module pbit_hist_bank
    import pbit_pkg::*;
#(
    parameter int NBITS = 3,
    parameter int CW    = 16
) (
    input  logic             CLK,
    input  logic             clear_en,
    input  logic [NBITS-1:0] clear_idx,
    input  logic             inc_en,
    input  logic [NBITS-1:0] inc_idx,
    input  logic [NBITS-1:0] rd_idx,
    output logic [CW-1:0]    rd_data,
    output logic             sat
);

    localparam int NBINS = 1 << NBITS;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_NEAR = CNT_MAX - CW'(1);

    logic [CW-1:0] bin_r [NBINS];

    // Clear has priority; a counter already at full scale holds its value.
    always_ff @(posedge CLK) begin
        if (clear_en) begin
            bin_r[clear_idx] <= '0;
        end else if (inc_en && (bin_r[inc_idx] != CNT_MAX)) begin
            bin_r[inc_idx] <= bin_r[inc_idx] + CW'(1);
        end
    end

    assign rd_data = bin_r[rd_idx];
    // Flags any increment that lands on, or is blocked by, the full-scale value.
    assign sat     = inc_en && (bin_r[inc_idx] >= CNT_NEAR);

endmodule

// File: rtl/pbit_sample_histogram.sv
// Histogram reader for a p-bit array: clears, burns in, bins spin vectors and
// streams the bins out. Define PBIT_HIST_MOMENTS_EN to add per-bit +1 counters.
module pbit_sample_histogram
    import pbit_pkg::*;
#(
    parameter int NBITS = 3,
    parameter int CW    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CW-1:0]    burn_in,
    input  logic [CW-1:0]    num_samples,
    input  logic             s_valid,
    input  logic [NBITS-1:0] s_spin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [NBITS-1:0] rd_bin,
    output logic [CW-1:0]    rd_count,
    output logic             rd_last,
    output logic             rd_is_mag
);

    localparam int NBINS = 1 << NBITS;
    localparam int IW    = NBITS + 1;
`ifdef PBIT_HIST_MOMENTS_EN
    localparam int NBEATS = NBINS + NBITS;
`else
    localparam int NBEATS = NBINS;
`endif
    localparam logic [NBITS-1:0] LAST_BIN  = '1;
    localparam logic [IW-1:0]    LAST_BEAT = IW'(NBEATS - 1);
    localparam logic [CW-1:0]    CNT_MAX   = '1;
    localparam logic [CW-1:0]    CNT_NEAR  = CNT_MAX - CW'(1);

    hist_state_e      state_r;
    logic [NBITS-1:0] clr_idx_r;
    logic [CW-1:0]    burn_cnt_r;
    logic [CW-1:0]    samp_cnt_r;
    logic [IW-1:0]    dump_idx_r;
    logic             busy_r, done_r, overflow_r;
    logic             rd_valid_r, rd_last_r, rd_is_mag_r;
    logic [NBITS-1:0] rd_bin_r;
    logic [CW-1:0]    rd_count_r;

    logic             clear_en_s, inc_en_s, bank_sat_s, mom_sat_s;
    logic             beat_load_s, beat_is_mag_s;
    logic [CW-1:0]    bank_data_s, beat_count_s;
    logic [NBITS-1:0] beat_bin_s;

    // Bank enables follow the state register directly.
    always_comb begin
        clear_en_s  = (state_r == CLEAR);
        inc_en_s    = (state_r == COLLECT) && s_valid;
        beat_load_s = (state_r == DUMP) && (!rd_valid_r || (rd_ready && !rd_last_r));
    end

    pbit_hist_bank #(.NBITS(NBITS), .CW(CW)) u_bank (
        .CLK       (CLK),
        .clear_en  (clear_en_s),
        .clear_idx (clr_idx_r),
        .inc_en    (inc_en_s),
        .inc_idx   (s_spin),
        .rd_idx    (dump_idx_r[NBITS-1:0]),
        .rd_data   (bank_data_s),
        .sat       (bank_sat_s)
    );

`ifdef PBIT_HIST_MOMENTS_EN
    logic [CW-1:0] mom_cnt_r [NBITS];

    // Per-bit +1 occurrence counters, cleared alongside the bins.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NBITS; i++) begin
            if (clear_en_s) begin
                mom_cnt_r[i] <= '0;
            end else if (inc_en_s && s_spin[i] && (mom_cnt_r[i] != CNT_MAX)) begin
                mom_cnt_r[i] <= mom_cnt_r[i] + CW'(1);
            end
        end
    end

    // Same saturation rule as the bins.
    always_comb begin
        mom_sat_s = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            mom_sat_s = mom_sat_s | (inc_en_s & s_spin[i] & (mom_cnt_r[i] >= CNT_NEAR));
        end
    end

    // Beats past the last bin carry the moment counters.
    always_comb begin
        beat_bin_s    = dump_idx_r[NBITS-1:0];
        beat_count_s  = bank_data_s;
        beat_is_mag_s = 1'b0;
        if (dump_idx_r >= IW'(NBINS)) begin
            beat_bin_s    = NBITS'(dump_idx_r - IW'(NBINS));
            beat_is_mag_s = 1'b1;
            for (int i = 0; i < NBITS; i++) begin
                beat_count_s = (beat_bin_s == NBITS'(i)) ? mom_cnt_r[i] : beat_count_s;
            end
        end else begin
            beat_is_mag_s = 1'b0;
        end
    end
`else
    assign mom_sat_s = 1'b0;

    // Without moments every beat is a plain bin.
    always_comb begin
        beat_bin_s    = dump_idx_r[NBITS-1:0];
        beat_count_s  = bank_data_s;
        beat_is_mag_s = 1'b0;
    end
`endif

    // Run sequencer with registered status and readout outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            clr_idx_r   <= '0;
            burn_cnt_r  <= '0;
            samp_cnt_r  <= '0;
            dump_idx_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            rd_is_mag_r <= 1'b0;
            rd_bin_r    <= '0;
            rd_count_r  <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r    <= CLEAR;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        overflow_r <= 1'b0;
                        clr_idx_r  <= '0;
                        burn_cnt_r <= burn_in;
                        samp_cnt_r <= num_samples;
                    end
                end
                CLEAR: begin
                    clr_idx_r <= clr_idx_r + NBITS'(1);
                    if (clr_idx_r == LAST_BIN) begin
                        dump_idx_r <= '0;
                        if (burn_cnt_r != '0) begin
                            state_r <= BURN;
                        end else if (samp_cnt_r != '0) begin
                            state_r <= COLLECT;
                        end else begin
                            state_r <= DUMP;
                        end
                    end
                end
                BURN: begin
                    if (s_valid) begin
                        burn_cnt_r <= burn_cnt_r - CW'(1);
                        if (burn_cnt_r == CW'(1)) begin
                            state_r <= (samp_cnt_r != '0) ? COLLECT : DUMP;
                        end
                    end
                end
                COLLECT: begin
                    overflow_r <= overflow_r | bank_sat_s | mom_sat_s;
                    if (s_valid) begin
                        samp_cnt_r <= samp_cnt_r - CW'(1);
                        if (samp_cnt_r == CW'(1)) begin
                            state_r <= DUMP;
                        end
                    end
                end
                DUMP: begin
                    if (rd_valid_r && rd_ready && rd_last_r) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        rd_valid_r <= 1'b0;
                        rd_last_r  <= 1'b0;
                    end else if (beat_load_s) begin
                        rd_valid_r  <= 1'b1;
                        rd_bin_r    <= beat_bin_s;
                        rd_count_r  <= beat_count_s;
                        rd_is_mag_r <= beat_is_mag_s;
                        rd_last_r   <= (dump_idx_r == LAST_BEAT);
                        dump_idx_r  <= dump_idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;
    assign rd_valid  = rd_valid_r;
    assign rd_bin    = rd_bin_r;
    assign rd_count  = rd_count_r;
    assign rd_last   = rd_last_r;
    assign rd_is_mag = rd_is_mag_r;

endmodule
